// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive controller:
//               FSM state encoding, queue entry layout, reset-default line
//               configuration and a saturating byte-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_frame  = 2'd1;
    localparam state_t c_st_commit = 2'd2;

    // One received frame as held in the queue
    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } entry_t;

    // Line configuration applied out of reset: prescale 8, parity on, even
    localparam logic [5:0] c_rst_prescale = 6'd8;
    localparam logic       c_rst_par_en   = 1'b1;
    localparam logic       c_rst_par_type = 1'b0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO of entry_t words (DEPTH a power of two).
//               A push to a full queue is accepted only if the head is being
//               popped in the same cycle; otherwise it is dropped and 'drop'
//               pulses. The head reads as zero while the queue is empty.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write request / entry
//               pop             - consumer takes the head this cycle
//               valid, head     - queue non-empty / head entry
//               drop            - push rejected because the queue was full
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   valid,
    output entry_t head,
    output logic   drop
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw-1:0] c_ptr_one = 1;
    localparam logic [c_aw:0]   c_cnt_one = 1;
    localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic w_pop;
    logic w_full;
    logic w_push;

    assign w_pop  = pop && (r_count != '0);
    assign w_full = (r_count == c_depth);
    // With a simultaneous pop the slot frees in the same edge, so a full
    // queue can still take the new entry.
    assign w_push = push && (!w_full || w_pop);
    assign drop   = push && w_full && !w_pop;

    assign valid = (r_count != '0);
    assign head  = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Control wrapper around a UART receive datapath. Tracks each
//               frame from start edge to frame-end pulse (with a watchdog),
//               queues received bytes with their error status for a
//               valid/ready consumer, and owns the line configuration.
// Ports       : clk, rst                    - clock, sync active-high reset
//               rx_in                       - serial line (start detection)
//               data_valid/parity_error/stop_error, p_data - datapath status
//               cfg_wr, cfg_prescale, cfg_par_en, cfg_par_type - config write
//               prescale, parity_enable, parity_type          - applied config
//               out_valid/out_ready/out_data/out_perr/out_ferr - byte stream
//               ovf, abort, flag_clr        - sticky flags and their clear
//               perr_cnt, ferr_cnt          - error counters (optional)
//               busy                        - FSM not idle
// Options     : define UART_RX_CTRL_ERR_CNT_EN to add perr_cnt / ferr_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_BITS    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       data_valid,
    input  logic       parity_error,
    input  logic       stop_error,
    input  logic [7:0] p_data,
    input  logic       cfg_wr,
    input  logic [5:0] cfg_prescale,
    input  logic       cfg_par_en,
    input  logic       cfg_par_type,
    output logic [5:0] prescale,
    output logic       parity_enable,
    output logic       parity_type,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_perr,
    output logic       out_ferr,
    output logic       ovf,
    output logic       abort,
    input  logic       flag_clr,
`ifdef UART_RX_CTRL_ERR_CNT_EN
    output logic [7:0] perr_cnt,
    output logic [7:0] ferr_cnt,
`endif
    output logic       busy
);

    state_t     r_state;
    logic       r_rx;
    logic       r_rx_d;
    logic       r_dv;
    logic       r_pe;
    logic       r_se;
    logic [9:0] r_wd;
    entry_t     r_cap;
    logic       r_ovf;
    logic       r_abort;

    logic [5:0] r_prescale;
    logic       r_par_en;
    logic       r_par_type;
    logic       r_pend_v;
    logic [5:0] r_pend_prescale;
    logic       r_pend_par_en;
    logic       r_pend_par_type;

    logic        w_start;
    logic        w_end;
    logic [15:0] w_limit;
    logic        w_timeout;
    logic        w_commit;
    logic        w_drop;
    logic        w_cfg_ok;
    logic        w_cfg_direct;
    entry_t      w_head;

    // Start bit: falling edge seen on the registered line
    assign w_start = r_rx_d & ~r_rx;
    // Frame end: rising edge of any datapath status pulse
    assign w_end   = (data_valid & ~r_dv) | (parity_error & ~r_pe) | (stop_error & ~r_se);

    // Watchdog expires on the limit-th clock spent in FRAME
    assign w_limit   = 16'(r_prescale) * 16'(TO_BITS);
    assign w_timeout = (r_state == c_st_frame) && !w_end && (({6'd0, r_wd} + 16'd1) == w_limit);
    assign w_commit  = (r_state == c_st_commit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx   <= 1'b1;
            r_rx_d <= 1'b1;
            r_dv   <= 1'b0;
            r_pe   <= 1'b0;
            r_se   <= 1'b0;
        end else begin
            r_rx   <= rx_in;
            r_rx_d <= r_rx;
            r_dv   <= data_valid;
            r_pe   <= parity_error;
            r_se   <= stop_error;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_wd    <= '0;
            r_cap   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_wd <= '0;
                    if (w_start) r_state <= c_st_frame;
                end
                c_st_frame: begin
                    if (w_end) begin
                        r_cap   <= '{data: p_data, perr: parity_error, ferr: stop_error};
                        r_state <= c_st_commit;
                    end else if (w_timeout) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_wd <= r_wd + 10'd1;
                    end
                end
                c_st_commit: r_state <= c_st_idle;
                default:     r_state <= c_st_idle;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_commit),
        .push_data(r_cap),
        .pop      (out_ready),
        .valid    (out_valid),
        .head     (w_head),
        .drop     (w_drop)
    );

    assign out_data = w_head.data;
    assign out_perr = w_head.perr;
    assign out_ferr = w_head.ferr;

    // Sticky flags: a set in the same cycle as flag_clr wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_ovf   <= w_drop    | (r_ovf   & ~flag_clr);
            r_abort <= w_timeout | (r_abort & ~flag_clr);
        end
    end

    assign ovf   = r_ovf;
    assign abort = r_abort;
    assign busy  = (r_state != c_st_idle);

    // Configuration: immediate when idle and no frame is starting, otherwise
    // parked and applied on the first IDLE cycle. Zero prescale is rejected.
    assign w_cfg_ok     = cfg_wr && (cfg_prescale != 6'd0);
    assign w_cfg_direct = (r_state == c_st_idle) && !w_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale      <= c_rst_prescale;
            r_par_en        <= c_rst_par_en;
            r_par_type      <= c_rst_par_type;
            r_pend_v        <= 1'b0;
            r_pend_prescale <= c_rst_prescale;
            r_pend_par_en   <= c_rst_par_en;
            r_pend_par_type <= c_rst_par_type;
        end else if (w_cfg_ok && w_cfg_direct) begin
            r_prescale <= cfg_prescale;
            r_par_en   <= cfg_par_en;
            r_par_type <= cfg_par_type;
            r_pend_v   <= 1'b0;
        end else if (w_cfg_ok) begin
            r_pend_v        <= 1'b1;
            r_pend_prescale <= cfg_prescale;
            r_pend_par_en   <= cfg_par_en;
            r_pend_par_type <= cfg_par_type;
        end else if ((r_state == c_st_idle) && r_pend_v) begin
            r_prescale <= r_pend_prescale;
            r_par_en   <= r_pend_par_en;
            r_par_type <= r_pend_par_type;
            r_pend_v   <= 1'b0;
        end
    end

    assign prescale      = r_prescale;
    assign parity_enable = r_par_en;
    assign parity_type   = r_par_type;

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] r_perr_cnt;
    logic [7:0] r_ferr_cnt;

    // Counts every committed frame, whether or not the queue accepted it
    always_ff @(posedge clk) begin
        if (rst || flag_clr) begin
            r_perr_cnt <= '0;
            r_ferr_cnt <= '0;
        end else if (w_commit) begin
            if (r_cap.perr) r_perr_cnt <= sat_inc8(r_perr_cnt);
            if (r_cap.ferr) r_ferr_cnt <= sat_inc8(r_ferr_cnt);
        end
    end

    assign perr_cnt = r_perr_cnt;
    assign ferr_cnt = r_ferr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. Expected queue entries
//               are pushed to a scoreboard as frames are issued; a monitor
//               pops and compares on every stream transfer. Status outputs
//               are compared directly against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic [7:0] p_data;
    logic       cfg_wr;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_type;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_ferr;
    logic       ovf;
    logic       abort;
    logic       flag_clr;
    logic       busy;
`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] perr_cnt;
    logic [7:0] ferr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb [$];
    logic [9:0] mon_exp;

    uart_rx_ctrl #(
        .FIFO_DEPTH(4),
        .TO_BITS   (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .p_data       (p_data),
        .cfg_wr       (cfg_wr),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_type (cfg_par_type),
        .prescale     (prescale),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_perr     (out_perr),
        .out_ferr     (out_ferr),
        .ovf          (ovf),
        .abort        (abort),
        .flag_clr     (flag_clr),
`ifdef UART_RX_CTRL_ERR_CNT_EN
        .perr_cnt     (perr_cnt),
        .ferr_cnt     (ferr_cnt),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {22'd0, out_data, out_perr, out_ferr}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb.pop_front();
                check("stream_entry", {22'd0, out_data, out_perr, out_ferr}, {22'd0, mon_exp});
            end
        end
    end

    // One frame: start edge, a few clocks in FRAME, then a frame-end pulse.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic se,
                              input logic exp_push, input logic rdy_commit,
                              input logic clr_commit);
        logic keep;
        rx_in = 1'b0;
        repeat (3) tick();
        rx_in = 1'b1;
        repeat (2) tick();
        p_data       = d;
        data_valid   = 1'b1;
        parity_error = pe;
        stop_error   = se;
        if (exp_push) sb.push_back({d, pe, se});
        tick();                                   // COMMIT cycle
        data_valid   = 1'b0;
        parity_error = 1'b0;
        stop_error   = 1'b0;
        keep = out_ready;
        if (rdy_commit) out_ready = 1'b1;
        if (clr_commit) flag_clr  = 1'b1;
        tick();
        out_ready = keep;
        flag_clr  = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
        check("drain_complete", sb.size(), 0);
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    task automatic cfg(input logic [5:0] ps, input logic en, input logic ty);
        cfg_wr       = 1'b1;
        cfg_prescale = ps;
        cfg_par_en   = en;
        cfg_par_type = ty;
        tick();
        cfg_wr = 1'b0;
    endtask

    // Start glitch; returns the number of clocks the FSM spent busy
    task automatic glitch(output int cnt);
        cnt   = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 2) rx_in = 1'b1;
            if (busy) cnt++;
            else if (cnt != 0) break;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst          = 1'b1;
        rx_in        = 1'b1;
        data_valid   = 1'b0;
        parity_error = 1'b0;
        stop_error   = 1'b0;
        p_data       = 8'h00;
        cfg_wr       = 1'b0;
        cfg_prescale = 6'd0;
        cfg_par_en   = 1'b0;
        cfg_par_type = 1'b0;
        out_ready    = 1'b0;
        flag_clr     = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_prescale",  prescale, 8);
        check("rst_par_en",    parity_enable, 1);
        check("rst_par_type",  parity_type, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  {out_data, out_perr, out_ferr}, 0);
        check("rst_flags",     {ovf, abort, busy}, 0);
        rst = 1'b0;
        tick();

        // Good frame 0xA5 with COMMIT-to-valid latency
        out_ready = 1'b1;
        rx_in = 1'b0;
        repeat (3) tick();
        rx_in = 1'b1;
        repeat (2) tick();
        check("busy_in_frame", busy, 1);
        p_data     = 8'hA5;
        data_valid = 1'b1;
        sb.push_back({8'hA5, 1'b0, 1'b0});
        tick();
        data_valid = 1'b0;
        check("commit_busy",      busy, 1);
        check("commit_no_valid",  out_valid, 0);
        tick();
        check("valid_after_commit", out_valid, 1);
        check("idle_after_commit",  busy, 0);
        tick();
        wait_drain();

        // Overflow: five frames into a depth-4 queue with no consumer.
        // The dropping push coincides with flag_clr, so ovf must still set.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("no_ovf_at_four", ovf, 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_set", ovf, 1);
        check("head_held", out_data, 8'h11);
        pulse_clr();
        check("ovf_cleared", ovf, 0);

        // Full queue, push with a same-cycle transfer: accepted, no ovf
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("full_push_pop_no_ovf", ovf, 0);
        check("head_after_pop", out_data, 8'h22);
        out_ready = 1'b1;
        wait_drain();
        tick();
        check("empty_after_drain", out_valid, 0);

        // Configuration
        cfg(6'd0, 1'b0, 1'b1);
        check("cfg_zero_ignored", {prescale, parity_enable, parity_type}, {6'd8, 1'b1, 1'b0});
        cfg(6'd10, 1'b1, 1'b1);
        check("cfg_idle_direct", {prescale, parity_type}, {6'd10, 1'b1});
        cfg(6'd8, 1'b1, 1'b0);
        rx_in = 1'b0;
        repeat (3) tick();
        rx_in = 1'b1;
        repeat (2) tick();
        cfg(6'd16, 1'b0, 1'b1);
        check("cfg_held_in_frame", prescale, 8);
        check("busy_frame_cfg", busy, 1);
        p_data     = 8'h5A;
        data_valid = 1'b1;
        sb.push_back({8'h5A, 1'b0, 1'b0});
        tick();
        data_valid = 1'b0;
        check("cfg_held_in_commit", {busy, prescale}, {1'b1, 6'd8});
        tick();
        check("idle_after_cfg_frame", busy, 0);
        repeat (2) tick();
        check("cfg_applied_after_idle", {prescale, parity_enable, parity_type}, {6'd16, 1'b0, 1'b1});
        cfg(6'd8, 1'b1, 1'b0);
        wait_drain();

        // Start glitch: watchdog 8*12 = 96 clocks in FRAME, then abort
        glitch(cnt);
        check("watchdog_clocks", cnt, 96);
        check("abort_set", abort, 1);
        check("abort_no_push", out_valid, 0);
        check("abort_idle", busy, 0);
        pulse_clr();
        check("abort_cleared", abort, 0);

        // Error frames
        pulse_clr();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain();
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain();
`ifdef UART_RX_CTRL_ERR_CNT_EN
        check("ferr_cnt_one", ferr_cnt, 1);
        check("perr_cnt_one", perr_cnt, 1);
        for (int i = 0; i < 299; i++) begin
            send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        wait_drain();
        check("ferr_cnt_saturated", ferr_cnt, 255);
        check("perr_cnt_unchanged", perr_cnt, 1);
`endif

        // Reset mid-frame with queued data, abort set and a pending config
        glitch(cnt);
        out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", {out_valid, abort}, 2'b11);
        rx_in = 1'b0;
        repeat (3) tick();
        rx_in = 1'b1;
        repeat (2) tick();
        cfg(6'd20, 1'b0, 1'b1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        sb.delete();
        check("midrst_stream", {out_valid, out_data, out_perr, out_ferr}, 0);
        check("midrst_flags", {ovf, abort, busy}, 0);
        check("midrst_cfg", {prescale, parity_enable, parity_type}, {6'd8, 1'b1, 1'b0});
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_pending_gone", prescale, 8);
        check("post_rst_quiet", {out_valid, abort, ovf, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the received-byte queue depth (power of two, 2..16).
REQ-002 Parameter TO_BITS, default 12, SHALL set the frame watchdog length in bit periods.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_in  in  1  serial line, the same signal driven to the receive datapath.
REQ-006 data_valid, parity_error, stop_error  in  1 each  frame-status pulses from the receive datapath.
REQ-007 p_data  in  8  parallel byte from the receive datapath.
REQ-008 cfg_wr  in  1; cfg_prescale  in  6; cfg_par_en  in  1; cfg_par_type  in  1  configuration write request and values.
REQ-009 prescale  out  6; parity_enable  out  1; parity_type  out  1  applied configuration driven to the datapath.
REQ-010 out_valid  out  1; out_ready  in  1; out_data  out  8; out_perr  out  1; out_ferr  out  1  consumer stream.
REQ-011 ovf  out  1; abort  out  1; flag_clr  in  1  sticky overflow and abort flags, plus their clear.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, FRAME and COMMIT.
REQ-014 rx_in SHALL be registered once; in IDLE, a registered 1->0 transition SHALL move the FSM to FRAME on the next cycle.
REQ-015 A frame-end event SHALL be the rising edge of data_valid, parity_error or stop_error, detected against a registered copy of each input.
REQ-016 In FRAME, a frame-end event SHALL move the FSM to COMMIT and capture {p_data, parity_error, stop_error}.
REQ-017 COMMIT SHALL last exactly one cycle: push the captured entry to the queue, then return to IDLE.
REQ-018 In FRAME, a 10-bit watchdog SHALL count clocks; reaching prescale*TO_BITS without a frame-end event SHALL set abort, skip the push and return to IDLE.
REQ-019 A frame-end event while in IDLE SHALL be ignored.
REQ-020 A stream transfer SHALL occur when out_valid && out_ready are both high.
REQ-021 out_data, out_perr and out_ferr SHALL show the queue head and stay stable while out_valid && !out_ready.
REQ-022 Latency from entering COMMIT to out_valid high SHALL be 1 cycle when the queue is empty.
REQ-023 A push to a full queue SHALL be accepted if a transfer happens in the same cycle.
REQ-024 A push to a full queue with no transfer SHALL drop the new entry, keep the queue unchanged and set ovf.
REQ-025 The queue pointers SHALL wrap modulo FIFO_DEPTH; a count register SHALL distinguish full from empty.
REQ-026 ovf and abort SHALL stay high until flag_clr; a set and a clear in the same cycle SHALL leave the flag set.
REQ-027 A cfg_wr in IDLE, with no start edge in that cycle, SHALL update prescale/parity_enable/parity_type on the next cycle.
REQ-028 A cfg_wr in any other case SHALL be held pending and applied in the cycle after the FSM returns to IDLE.
REQ-029 A later cfg_wr SHALL overwrite a pending one.
REQ-030 A cfg_prescale value of 0 SHALL be ignored, with no update and no pending write.

Reset
REQ-031 During rst the FSM SHALL go to IDLE and the queue and pending config SHALL be emptied.
REQ-032 During rst, out_valid, ovf, abort and busy SHALL go to 0, and out_data, out_perr and out_ferr SHALL go to 0.
REQ-033 During rst, prescale SHALL go to 8, parity_enable to 1 and parity_type to 0.
REQ-034 rst asserted mid-frame SHALL discard the frame, with no push and no flag set.

Configuration
REQ-035 With UART_RX_CTRL_ERR_CNT_EN defined, outputs perr_cnt [7:0] and ferr_cnt [7:0] SHALL exist.
REQ-036 These counters SHALL count committed entries with parity or stop error respectively, saturate at 255, and reset to 0 on rst or flag_clr.
REQ-037 Without UART_RX_CTRL_ERR_CNT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-038 A shared package uart_rx_pkg SHALL hold the FSM state enum, the entry struct {data, perr, ferr} and the reset-default constants (prescale 8, parity enabled, even).
REQ-039 The queue SHALL be a separate sub-module uart_rx_fifo (sync FIFO, FIFO_DEPTH entries of the entry struct).

Verification
REQ-040 Good frame 0xA5 at prescale 8 -> one commit; out_data=0xA5, perr=0, ferr=0; out_valid 1 cycle after COMMIT.
REQ-041 Five frames with out_ready=0 and FIFO_DEPTH 4 -> fifth byte dropped, ovf=1, four entries drained in order afterwards.
REQ-042 Start glitch (rx_in low 3 clocks) at prescale 8 -> abort=1 after 96 clocks in FRAME, queue empty, FSM IDLE.
REQ-043 cfg_wr prescale=16 mid-frame -> prescale stays 8 until commit, then 16 one cycle after IDLE; busy tracks FRAME/COMMIT.
REQ-044 Frame with stop_error and ERR_CNT_EN defined -> ferr=1 on output, ferr_cnt=1; 300 such frames -> ferr_cnt=255.
REQ-045 Full queue with push and transfer in the same cycle -> no ovf, count stays 4; rst mid-frame -> all outputs at reset values next cycle.
